lane_gen: RTL and testbench
===========================

Name: lane_gen

Overview:
Downstream consumer of the vertical scroller's move_followers pulse. Keeps an 8-lane shift register of world rows (grass or road, car direction, car x position) and a sub-lane scroll offset. Inserts a pseudo-random new lane at the top each time the scroll crosses a lane boundary, and advances cars horizontally once per frame. The pixel renderer and the collision logic read its outputs.

Parameters:
NUM_LANES, 8, number of lanes held; lane 0 is the top, lane NUM_LANES-1 is the player row
LANE_H, 60, lane height in pixels; must be at most 64
MOVE_AMT, 2, pixels added to the offset per move_followers pulse; must match the scroller
CAR_STEP, 3, pixels a car moves per frame_tick
SCREEN_W, 640, horizontal wrap width for car_x

Ports:
clk  in  1  25 MHz pixel clock
reset_n  in  1  asynchronous active-low reset
move_followers  in  1  one-cycle pulse from the scroller; one scroll step
frame_tick  in  1  one-cycle pulse once per frame, at vsync start
lane_road  out  NUM_LANES  bit i = 1 when lane i is a road
lane_dir  out  NUM_LANES  bit i = 1 when lane i's car moves right
car_x  out  10*NUM_LANES  car x of lane i in bits [10i+9:10i]; range 0..SCREEN_W-1
lane_offset  out  6  sub-lane scroll offset, 0..LANE_H-MOVE_AMT
new_lane  out  1  one-cycle pulse when a lane is inserted

Behaviour:
- Reset (async assert, sync release): lane_road=0 (all grass), lane_dir=0, car_x all 0, lane_offset=0, new_lane=0, LFSR=16'hACE1.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). Steps every clk cycle while out of reset, so content depends on player timing.
- Offset, evaluated on each move_followers pulse:
  - if lane_offset+MOVE_AMT >= LANE_H: lane_offset <= 0 and a shift occurs.
  - otherwise lane_offset <= lane_offset+MOVE_AMT.
  - Defaults: 29 pulses give 58; the 30th gives 0 plus a shift.
- Shift, same cycle as the wrapping pulse:
  - lane[i] <= lane[i-1] for i = 1..NUM_LANES-1. The old bottom lane is discarded.
  - lane[0] takes the new lane, built from the current LFSR value:
    - road = lfsr[0]
    - dir = lfsr[1]
    - car_x = {1'b0, lfsr[10:2]} (0..511, always < SCREEN_W)
  - new_lane = 1 for exactly that cycle; otherwise 0.
- Road-run limit: if the pre-shift lanes 0, 1 and 2 are all road, the new lane is forced to grass, with dir=0 and car_x=0. Never 4 consecutive roads.
- Car motion, on frame_tick, road lanes only (grass lanes hold car_x):
  - dir=1: if car_x+CAR_STEP >= SCREEN_W then car_x+CAR_STEP-SCREEN_W, else car_x+CAR_STEP.
  - dir=0: if car_x < CAR_STEP then car_x+SCREEN_W-CAR_STEP, else car_x-CAR_STEP.
- frame_tick and a shifting move_followers in the same cycle: motion is applied first, then the shift. Lane i (i >= 1) receives the moved car_x of old lane i-1. The inserted lane 0 takes the raw LFSR x, not moved.
- All arithmetic is done at 11 bits to avoid overflow before the compare.
- All outputs are registered; a change is visible the cycle after the triggering pulse.
- Pulses wider than one cycle are treated as one event per high cycle (no edge detect).
- reset_n asserted mid-operation restores reset values immediately.
- The bottom lane is not forced safe after reset. The player row is guaranteed grass only until the first NUM_LANES-1 shifts; the collision logic owns the consequences.

Test Plan:
- Reset: hold reset_n=0, then release -> all outputs 0 and LFSR=16'hACE1 on the first cycle after release.
- Offset: 29 move_followers pulses -> lane_offset=58, no new_lane. 30th pulse -> lane_offset=0, new_lane high for 1 cycle, old lane_road[0] appears in lane_road[1].
- Road limit: force the LFSR so three successive inserts have lfsr[0]=1 (lanes 0..2 road), then a fourth with lfsr[0]=1 -> inserted lane_road[0]=0, car_x=0.
- Right wrap: road lane, dir=1, car_x=638, one frame_tick -> car_x=1. Left wrap: dir=0, car_x=2 -> 639. Grass lane with car_x=100 -> stays 100.
- Simultaneous: lane 0 road, dir=1, car_x=10; frame_tick and the 30th move_followers in the same cycle -> lane 1 car_x=13, lane_offset=0, new_lane=1.
- Async reset mid-operation: assert reset_n between clock edges with lane_offset=40 -> outputs clear before the next edge.

Source files
------------

// File: rtl/lane_gen.sv
// lane_gen: world-row generator for the vertical scroller.
// Holds NUM_LANES lanes (lane 0 on top, lane NUM_LANES-1 is the player row),
// each with a road/grass flag, a car direction and a car x position, plus the
// sub-lane scroll offset. Every time the offset crosses a lane boundary the
// lanes shift down by one and a pseudo-random lane enters at the top. Cars on
// road lanes advance CAR_STEP pixels per frame and wrap at SCREEN_W.
// LANE_H must be at most 64 so the offset fits in 6 bits; NUM_LANES must be
// at least 3 for the road-run limit.

module lane_gen #(
    parameter int NUM_LANES = 8,
    parameter int LANE_H    = 60,
    parameter int MOVE_AMT  = 2,
    parameter int CAR_STEP  = 3,
    parameter int SCREEN_W  = 640
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    move_followers,
    input  logic                    frame_tick,
    output logic [NUM_LANES-1:0]    lane_road,
    output logic [NUM_LANES-1:0]    lane_dir,
    output logic [10*NUM_LANES-1:0] car_x,
    output logic [5:0]              lane_offset,
    output logic                    new_lane
);

    // All position arithmetic is carried at 11 bits so sums such as
    // 639 + CAR_STEP cannot overflow before the wrap compare.
    localparam logic [10:0] LANE_H_11   = 11'(LANE_H);
    localparam logic [10:0] MOVE_AMT_11 = 11'(MOVE_AMT);
    localparam logic [10:0] CAR_STEP_11 = 11'(CAR_STEP);
    localparam logic [10:0] SCREEN_W_11 = 11'(SCREEN_W);
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    localparam int XW = 10 * NUM_LANES;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]          lfsr_q;
    logic [5:0]           offset_q;
    logic                 new_lane_q;
    logic [NUM_LANES-1:0] road_q;
    logic [NUM_LANES-1:0] dir_q;
    logic [XW-1:0]        x_q;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [15:0]          lfsr_d;
    logic [10:0]          offset_sum;
    logic                 wrap;
    logic [5:0]           offset_d;
    logic [XW-1:0]        moved_x;
    logic                 run_full;
    logic                 ins_road;
    logic                 ins_dir;
    logic [9:0]           ins_x;
    logic [NUM_LANES-1:0] road_d;
    logic [NUM_LANES-1:0] dir_d;
    logic [XW-1:0]        x_d;

    // Galois LFSR, x^16+x^14+x^13+x^11: shift right, fold the tap mask in
    // whenever a one falls out of bit 0.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // Offset advance and lane-boundary detection. Each high cycle of
    // move_followers counts as one scroll step.
    assign offset_sum = 11'(offset_q) + MOVE_AMT_11;
    assign wrap       = move_followers && (offset_sum >= LANE_H_11);

    always_comb begin
        offset_d = offset_q;
        if (wrap) begin
            offset_d = '0;
        end else if (move_followers) begin
            offset_d = 6'(offset_sum);
        end
    end

    // Horizontal car motion per lane. Only road lanes move; grass lanes
    // keep their stored x untouched.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_motion
        logic [10:0] x_ext;
        logic [10:0] fwd;
        logic [10:0] fwd_wrapped;
        logic [10:0] back;
        logic [10:0] back_wrapped;
        logic        moving;

        assign x_ext        = {1'b0, x_q[10*g +: 10]};
        assign fwd          = x_ext + CAR_STEP_11;
        assign fwd_wrapped  = fwd - SCREEN_W_11;
        assign back         = x_ext - CAR_STEP_11;
        assign back_wrapped = x_ext + SCREEN_W_11 - CAR_STEP_11;
        assign moving       = frame_tick && road_q[g];

        assign moved_x[10*g +: 10] =
            !moving   ? x_q[10*g +: 10] :
            dir_q[g]  ? ((fwd >= SCREEN_W_11)  ? 10'(fwd_wrapped)  : 10'(fwd)) :
                        ((x_ext < CAR_STEP_11) ? 10'(back_wrapped) : 10'(back));
    end

    // Candidate top lane. Three roads already stacked at the top force a
    // plain grass lane so the player never faces four roads in a row.
    assign run_full = road_q[0] & road_q[1] & road_q[2];
    assign ins_road = lfsr_q[0] & ~run_full;
    assign ins_dir  = lfsr_q[1] & ~run_full;
    assign ins_x    = run_full ? 10'd0 : {1'b0, lfsr_q[10:2]};

    // Lane contents: motion always applies first; on a wrap the moved lanes
    // slide down one slot, the bottom lane drops out and the raw LFSR lane
    // enters at the top.
    // NOTE: every signal assigned in an always_comb gets a default on the
    // first lines so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        road_d = road_q;
        dir_d  = dir_q;
        x_d    = moved_x;
        if (wrap) begin
            road_d = {road_q[NUM_LANES-2:0], ins_road};
            dir_d  = {dir_q[NUM_LANES-2:0], ins_dir};
            x_d    = {moved_x[XW-11:0], ins_x};
        end
    end

    // Free-running LFSR; its value at the wrap edge depends on player timing.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Scroll offset and the one-cycle new-lane strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset_q   <= '0;
            new_lane_q <= 1'b0;
        end else begin
            offset_q   <= offset_d;
            new_lane_q <= wrap;
        end
    end

    // Lane shift register; reset leaves every lane as parked grass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            road_q <= '0;
            dir_q  <= '0;
            x_q    <= '0;
        end else begin
            road_q <= road_d;
            dir_q  <= dir_d;
            x_q    <= x_d;
        end
    end

    assign lane_road   = road_q;
    assign lane_dir    = dir_q;
    assign car_x       = x_q;
    assign lane_offset = offset_q;
    assign new_lane    = new_lane_q;

endmodule

// File: tb/tb_lane_gen.sv
// tb_lane_gen: directed bench for lane_gen with default parameters.
// A small behavioural model (LFSR, lanes, offset) follows every clock so
// random lane contents can be predicted; boundary cases are checked against
// hand-derived constants.

module tb_lane_gen;

    localparam int N = 8;

    logic          clk;
    logic          reset_n;
    logic          move_followers;
    logic          frame_tick;
    logic [N-1:0]  lane_road;
    logic [N-1:0]  lane_dir;
    logic [10*N-1:0] car_x;
    logic [5:0]    lane_offset;
    logic          new_lane;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_road [N];
    bit          m_dir  [N];
    int          m_x    [N];
    int          m_off;
    bit          m_new;
    logic [15:0] m_lfsr;

    lane_gen dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .move_followers (move_followers),
        .frame_tick     (frame_tick),
        .lane_road      (lane_road),
        .lane_dir       (lane_dir),
        .car_x          (car_x),
        .lane_offset    (lane_offset),
        .new_lane       (new_lane)
    );

    // 25 MHz pixel clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_road[i] = 0;
            m_dir[i]  = 0;
            m_x[i]    = 0;
        end
        m_off  = 0;
        m_new  = 0;
        m_lfsr = 16'hACE1;
    endtask

    // One rising edge of the model, written from the behavioural description.
    task automatic model_edge(input bit mf, input bit ft);
        int mx [N];
        bit run;
        bit wrap;
        for (int i = 0; i < N; i++) begin
            mx[i] = m_x[i];
            if (ft && m_road[i])
                mx[i] = m_dir[i] ? (m_x[i] + 3) % 640 : (m_x[i] + 637) % 640;
        end
        run  = m_road[0] && m_road[1] && m_road[2];
        wrap = mf && (m_off + 2 >= 60);
        if (wrap)    m_off = 0;
        else if (mf) m_off = m_off + 2;
        if (wrap) begin
            for (int i = N - 1; i >= 1; i--) begin
                m_road[i] = m_road[i-1];
                m_dir[i]  = m_dir[i-1];
                m_x[i]    = mx[i-1];
            end
            m_road[0] = run ? 1'b0 : m_lfsr[0];
            m_dir[0]  = run ? 1'b0 : m_lfsr[1];
            m_x[0]    = run ? 0 : int'(m_lfsr[10:2]);
        end else begin
            for (int i = 0; i < N; i++) m_x[i] = mx[i];
        end
        m_new  = wrap;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
    task automatic cyc(input bit mf, input bit ft);
        move_followers = mf;
        frame_tick     = ft;
        @(posedge clk);
        if (reset_n) model_edge(mf, ft);
        #1;
        move_followers = 1'b0;
        frame_tick     = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0] r;
        logic [N-1:0] d;
        for (int i = 0; i < N; i++) begin
            r[i] = m_road[i];
            d[i] = m_dir[i];
        end
        chk({tag, ".road"}, 32'(lane_road), 32'(r));
        chk({tag, ".dir"}, 32'(lane_dir), 32'(d));
        for (int i = 0; i < N; i++)
            chk($sformatf("%s.x%0d", tag, i), 32'(car_x[10*i +: 10]), 32'(m_x[i]));
        chk({tag, ".offset"}, 32'(lane_offset), 32'(m_off));
        chk({tag, ".new_lane"}, 32'(new_lane), 32'(m_new));
    endtask

    // Idle until the model LFSR offers a lane matching the filter (bounded).
    task automatic wait_for(input logic [15:0] mask, input logic [15:0] val,
                            input int mod3, input int xmin);
        bit found;
        int xv;
        found = 0;
        for (int n = 0; n < 5000 && !found; n++) begin
            xv = int'(m_lfsr[10:2]);
            if (((m_lfsr & mask) == val) && (mod3 < 0 || xv % 3 == mod3) && xv >= xmin)
                found = 1;
            else
                cyc(1'b0, 1'b0);
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL wait_lfsr: observed found=%0d expected 1", found);
        end
    endtask

    // From offset 0: 29 steps to 58, pick the moment, then the wrapping step.
    task automatic do_insert(input logic [15:0] mask, input logic [15:0] val,
                             input int mod3, input int xmin);
        for (int i = 0; i < 29; i++) cyc(1'b1, 1'b0);
        wait_for(mask, val, mod3, xmin);
        cyc(1'b1, 1'b0);
    endtask

    initial begin
        int n;
        int held;
        bit hit;

        reset_n        = 1'b0;
        move_followers = 1'b0;
        frame_tick     = 1'b0;
        model_reset();

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset.road", 32'(lane_road), 32'd0);
        chk("reset.dir", 32'(lane_dir), 32'd0);
        chk("reset.car_x_or", 32'(|car_x), 32'd0);
        chk("reset.offset", 32'(lane_offset), 32'd0);
        chk("reset.new_lane", 32'(new_lane), 32'd0);

        // Offset: 29 steps reach 58 without a lane insert
        for (int i = 0; i < 29; i++) cyc(1'b1, 1'b0);
        chk("off29.offset", 32'(lane_offset), 32'd58);
        chk("off29.new_lane", 32'(new_lane), 32'd0);
        compare_all("off29");
        wait_for(16'h0001, 16'h0000, -1, 0);
        cyc(1'b1, 1'b0);
        chk("off30.offset", 32'(lane_offset), 32'd0);
        chk("off30.new_lane", 32'(new_lane), 32'd1);
        chk("off30.road1", 32'(lane_road[1]), 32'd0);
        chk("off30.road0", 32'(lane_road[0]), 32'd0);
        compare_all("off30");
        cyc(1'b0, 1'b0);
        chk("off31.new_lane", 32'(new_lane), 32'd0);

        // Road-run limit: three roads, then a road draw is forced to grass
        for (int k = 0; k < 3; k++) do_insert(16'h0001, 16'h0001, -1, 0);
        chk("run3.road", 32'(lane_road[2:0]), 32'd7);
        compare_all("run3");
        do_insert(16'h0001, 16'h0001, -1, 0);
        chk("run4.road0", 32'(lane_road[0]), 32'd0);
        chk("run4.dir0", 32'(lane_dir[0]), 32'd0);
        chk("run4.x0", 32'(car_x[9:0]), 32'd0);
        chk("run4.road31", 32'(lane_road[3:1]), 32'd7);
        compare_all("run4");

        // Right wrap: road moving right, walk it to 638, then one more frame
        do_insert(16'h0003, 16'h0003, 2, 0);
        chk("rwrap.road0", 32'(lane_road[0]), 32'd1);
        chk("rwrap.dir0", 32'(lane_dir[0]), 32'd1);
        n = (638 - m_x[0]) / 3;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
        chk("rwrap.x638", 32'(car_x[9:0]), 32'd638);
        cyc(1'b0, 1'b1);
        chk("rwrap.x1", 32'(car_x[9:0]), 32'd1);
        compare_all("rwrap");

        // Left wrap: road moving left, walk it to 2, then one more frame
        do_insert(16'h0003, 16'h0001, 2, 0);
        chk("lwrap.road0", 32'(lane_road[0]), 32'd1);
        chk("lwrap.dir0", 32'(lane_dir[0]), 32'd0);
        n = (m_x[0] - 2) / 3;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
        chk("lwrap.x2", 32'(car_x[9:0]), 32'd2);
        cyc(1'b0, 1'b1);
        chk("lwrap.x639", 32'(car_x[9:0]), 32'd639);
        compare_all("lwrap");

        // Grass lane with a non-zero x holds it across frames
        do_insert(16'h0001, 16'h0000, -1, 1);
        chk("grass.road0", 32'(lane_road[0]), 32'd0);
        held = m_x[0];
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
        chk("grass.hold", 32'(car_x[9:0]), 32'(held));
        compare_all("grass");

        // Simultaneous frame_tick and wrapping step: lane 1 gets moved x
        do_insert(16'h0003, 16'h0003, -1, 0);
        hit = (m_x[0] == 10);
        for (int i = 0; i < 700 && !hit; i++) begin
            cyc(1'b0, 1'b1);
            hit = (m_x[0] == 10);
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL sim_reach10: observed hit=%0d expected 1", hit);
        end
        chk("sim.x0_10", 32'(car_x[9:0]), 32'd10);
        for (int i = 0; i < 29; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("sim.x1_13", 32'(car_x[19:10]), 32'd13);
        chk("sim.offset", 32'(lane_offset), 32'd0);
        chk("sim.new_lane", 32'(new_lane), 32'd1);
        compare_all("sim");

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        chk("mid.offset40", 32'(lane_offset), 32'd40);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid.road", 32'(lane_road), 32'd0);
        chk("mid.dir", 32'(lane_dir), 32'd0);
        chk("mid.car_x_or", 32'(|car_x), 32'd0);
        chk("mid.offset", 32'(lane_offset), 32'd0);
        chk("mid.new_lane", 32'(new_lane), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // After release the LFSR restarts from its seed
        cyc(1'b1, 1'b0);
        chk("post.offset", 32'(lane_offset), 32'd2);
        for (int i = 0; i < 29; i++) cyc(1'b1, 1'b0);
        chk("post.new_lane", 32'(new_lane), 32'd1);
        compare_all("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
